dma_wb_engine: RTL and testbench

DMA_WB_ENGINE -- requirements
Module: dma_wb_engine

---
 rtl/snn_soc_pkg.sv | 18 +
 rtl/dma_wb_engine.sv | 186 ++++++++++++++++++
 tb/tb_dma_wb_engine.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/snn_soc_pkg.sv
// Shared SoC constants: DMA engine register map, CTRL bit positions and
// output-FIFO entry width.
package snn_soc_pkg;

  localparam int ENTRY_W = 49;

  localparam logic [7:0] REG_DST_ADDR   = 8'h00;
  localparam logic [7:0] REG_LEN_WORDS  = 8'h04;
  localparam logic [7:0] REG_CTRL       = 8'h08;
  localparam logic [7:0] REG_WORDS_DONE = 8'h0C;

  localparam int CTRL_START = 0;
  localparam int CTRL_DONE  = 1;
  localparam int CTRL_ERR   = 2;
  localparam int CTRL_BUSY  = 3;
  localparam int CTRL_ABORT = 4;

endpackage

// File: rtl/dma_wb_engine.sv
// DMA write-back engine: drains 49-bit output-FIFO entries into data_sram
// as two consecutive 32-bit words (low 32 bits, then the upper 17 bits).
//
// state | meaning
// IDLE  | no transfer; START is evaluated here
// POP   | waiting for a FIFO entry; pops and captures it when present
// WR0   | writes entry[31:0] to ptr
// WR1   | writes entry[48:32] to ptr; retires two words, ends on the last pair
module dma_wb_engine
  import snn_soc_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  input  logic               req_write,
  input  logic [31:0]        req_addr,
  input  logic [31:0]        req_wdata,
  input  logic [3:0]         req_wstrb,
  output logic [31:0]        rdata,
  input  logic [ENTRY_W-1:0] out_fifo_rdata,
  input  logic               out_fifo_empty,
  output logic               out_fifo_pop,
  output logic               dma_wr_en,
  output logic [31:0]        dma_wr_addr,
  output logic [31:0]        dma_wr_data
);

  typedef enum logic [1:0] {IDLE, POP, WR0, WR1} state_t;

  state_t             state, state_nxt;
  logic [31:0]        dst_addr, len_words, words_done, ptr, rem;
  logic [ENTRY_W-1:0] hold;
  logic               done, err;

  logic [7:0] reg_off;
  logic       ctrl_wr, busy, start_go, abort_go, start_bad;
  logic       set_done, set_err, clr_flags, load, capture, advance, retire;
  logic       unused_addr_hi;

  assign reg_off        = req_addr[7:0];
  assign unused_addr_hi = ^req_addr[31:8];
  assign ctrl_wr        = req_valid & req_write & (reg_off == REG_CTRL);
  assign busy           = (state != IDLE);
  assign start_go       = ctrl_wr & req_wdata[CTRL_START] & ~busy;
  assign abort_go       = ctrl_wr & req_wdata[CTRL_ABORT] & busy;
  assign start_bad      = len_words[0] | (dst_addr[1:0] != 2'b00);
  assign dma_wr_addr    = ptr;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state, bus strobes and datapath controls; abort suppresses any pop/write.
  always_comb begin
    state_nxt    = state;
    out_fifo_pop = 1'b0;
    dma_wr_en    = 1'b0;
    dma_wr_data  = '0;
    set_done     = 1'b0;
    set_err      = 1'b0;
    clr_flags    = 1'b0;
    load         = 1'b0;
    capture      = 1'b0;
    advance      = 1'b0;
    retire       = 1'b0;
    if (abort_go) begin
      state_nxt = IDLE;
      set_done  = 1'b1;
      set_err   = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start_go) begin
            if (start_bad) begin
              set_done = 1'b1;
              set_err  = 1'b1;
            end else if (len_words == '0) begin
              set_done = 1'b1;
            end else begin
              clr_flags = 1'b1;
              load      = 1'b1;
              state_nxt = POP;
            end
          end
        end
        POP: begin
          if (!out_fifo_empty) begin
            out_fifo_pop = 1'b1;
            capture      = 1'b1;
            state_nxt    = WR0;
          end
        end
        WR0: begin
          dma_wr_en   = 1'b1;
          dma_wr_data = hold[31:0];
          advance     = 1'b1;
          state_nxt   = WR1;
        end
        WR1: begin
          dma_wr_en   = 1'b1;
          dma_wr_data = {{(64-ENTRY_W){1'b0}}, hold[ENTRY_W-1:32]};
          advance     = 1'b1;
          retire      = 1'b1;
          if (rem == 32'd2) begin
            set_done  = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = POP;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Byte-enabled configuration registers; the running transfer uses its own copies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dst_addr  <= '0;
      len_words <= '0;
    end else if (req_valid && req_write) begin
      for (int b = 0; b < 4; b++) begin
        if (req_wstrb[b]) begin
          if (reg_off == REG_DST_ADDR)  dst_addr[8*b +: 8]  <= req_wdata[8*b +: 8];
          if (reg_off == REG_LEN_WORDS) len_words[8*b +: 8] <= req_wdata[8*b +: 8];
        end
      end
    end
  end

  // Transfer datapath: pointer, remaining words, progress counter, held entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr        <= '0;
      rem        <= '0;
      words_done <= '0;
      hold       <= '0;
    end else begin
      if (load) begin
        ptr        <= dst_addr;
        rem        <= len_words;
        words_done <= '0;
      end
      if (capture) hold <= out_fifo_rdata;
      if (advance) ptr <= ptr + 32'd4;
      if (retire) begin
        rem        <= rem - 32'd2;
        words_done <= words_done + 32'd2;
      end
    end
  end

  // DONE/ERR: hardware set beats START clear, which beats software W1C.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done <= 1'b0;
      err  <= 1'b0;
    end else begin
      if (set_done)                         done <= 1'b1;
      else if (clr_flags)                   done <= 1'b0;
      else if (ctrl_wr && req_wdata[CTRL_DONE]) done <= 1'b0;
      if (set_err)                          err <= 1'b1;
      else if (clr_flags)                   err <= 1'b0;
      else if (ctrl_wr && req_wdata[CTRL_ERR])  err <= 1'b0;
    end
  end

  // Combinational register readback; START/ABORT read as zero.
  always_comb begin
    rdata = '0;
    case (reg_off)
      REG_DST_ADDR:   rdata = dst_addr;
      REG_LEN_WORDS:  rdata = len_words;
      REG_CTRL: begin
        rdata[CTRL_DONE] = done;
        rdata[CTRL_ERR]  = err;
        rdata[CTRL_BUSY] = busy;
      end
      REG_WORDS_DONE: rdata = words_done;
      default:        rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_dma_wb_engine.sv
// Bench for dma_wb_engine: FIFO environment, transfer-level reference model
// compared every cycle, directed scenarios with literal expectations, then
// randomized bus/FIFO traffic.
module tb_dma_wb_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic [31:0] rdata;
  logic [48:0] out_fifo_rdata = '0;
  logic        out_fifo_empty = 1'b1;
  logic        out_fifo_pop, dma_wr_en;
  logic [31:0] dma_wr_addr, dma_wr_data;

  always #5 clk = ~clk;

  dma_wb_engine dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .rdata(rdata),
    .out_fifo_rdata(out_fifo_rdata), .out_fifo_empty(out_fifo_empty),
    .out_fifo_pop(out_fifo_pop), .dma_wr_en(dma_wr_en),
    .dma_wr_addr(dma_wr_addr), .dma_wr_data(dma_wr_data)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // FIFO environment
  logic [48:0] fq[$];
  typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
  wr_t wlog[$];
  int pop_cnt = 0;

  task automatic fifo_drive();
    logic [63:0] g;
    g = {$urandom(), $urandom()};
    out_fifo_empty = (fq.size() == 0);
    out_fifo_rdata = out_fifo_empty ? g[48:0] : fq[0];
  endtask
  task automatic push(input logic [48:0] e);
    fq.push_back(e);
    fifo_drive();
  endtask
  task automatic flush();
    fq.delete();
    fifo_drive();
  endtask

  // Reference model: a transfer is "words left to write" plus how many
  // halves of the currently held entry still need writing.
  logic [31:0] m_dst = '0, m_len = '0, m_wd = '0, m_ptr = '0, m_left = '0;
  logic [48:0] m_hold = '0;
  logic        m_done = 1'b0, m_err = 1'b0, m_active = 1'b0;
  int          m_halves = 0;

  task automatic model_clear();
    m_dst = '0; m_len = '0; m_wd = '0; m_ptr = '0; m_left = '0; m_hold = '0;
    m_done = 1'b0; m_err = 1'b0; m_active = 1'b0; m_halves = 0;
  endtask

  task automatic model_cycle(input logic do_step);
    logic        wr, cw, st, ab, empty, e_pop, e_we, sd, se, cl;
    logic [7:0]  off;
    logic [31:0] e_data, e_rd;
    wr    = req_valid && req_write;
    off   = req_addr[7:0];
    cw    = wr && (off == 8'h08);
    st    = cw && req_wdata[0];
    ab    = cw && req_wdata[4];
    empty = (fq.size() == 0);
    e_pop = m_active && (m_halves == 0) && !empty && !ab;
    e_we  = m_active && (m_halves != 0) && !ab;
    e_data = !e_we ? 32'h0 : (m_halves == 2) ? m_hold[31:0] : {15'h0, m_hold[48:32]};
    case (off)
      8'h00:   e_rd = m_dst;
      8'h04:   e_rd = m_len;
      8'h08:   e_rd = {28'h0, m_active, m_err, m_done, 1'b0};
      8'h0C:   e_rd = m_wd;
      default: e_rd = 32'h0;
    endcase
    check("cyc_pop", 64'(out_fifo_pop), 64'(e_pop));
    check("cyc_wr_en", 64'(dma_wr_en), 64'(e_we));
    check("cyc_wr_addr", 64'(dma_wr_addr), 64'(m_ptr));
    check("cyc_wr_data", 64'(dma_wr_data), 64'(e_data));
    check("cyc_rdata", 64'(rdata), 64'(e_rd));
    if (do_step) begin
      sd = 1'b0; se = 1'b0; cl = 1'b0;
      if (m_active) begin
        if (ab) begin
          m_active = 1'b0; m_halves = 0; sd = 1'b1; se = 1'b1;
        end else if (m_halves == 0) begin
          if (!empty) begin m_hold = fq[0]; m_halves = 2; end
        end else begin
          m_ptr = m_ptr + 32'd4;
          m_halves--;
          if (m_halves == 0) begin
            m_left = m_left - 32'd2;
            m_wd   = m_wd + 32'd2;
            if (m_left == 0) begin m_active = 1'b0; sd = 1'b1; end
          end
        end
      end else if (st) begin
        if (m_len[0] || (m_dst[1:0] != 2'b00)) begin sd = 1'b1; se = 1'b1; end
        else if (m_len == 0) sd = 1'b1;
        else begin
          cl = 1'b1; m_wd = '0; m_ptr = m_dst; m_left = m_len; m_active = 1'b1; m_halves = 0;
        end
      end
      if (sd) m_done = 1'b1; else if (cl) m_done = 1'b0; else if (cw && req_wdata[1]) m_done = 1'b0;
      if (se) m_err = 1'b1;  else if (cl) m_err = 1'b0;  else if (cw && req_wdata[2]) m_err = 1'b0;
      if (wr) begin
        for (int b = 0; b < 4; b++) begin
          if (req_wstrb[b] && off == 8'h00) m_dst[8*b +: 8] = req_wdata[8*b +: 8];
          if (req_wstrb[b] && off == 8'h04) m_len[8*b +: 8] = req_wdata[8*b +: 8];
        end
      end
    end
  endtask

  // Single compare process: checks mid-cycle, FIFO pops just after the edge.
  logic obs_pop;
  always begin
    @(negedge clk);
    #3;
    if (!rst_n) model_clear();
    model_cycle(rst_n);
    obs_pop = out_fifo_pop;
    if (out_fifo_pop) pop_cnt++;
    if (dma_wr_en) wlog.push_back('{dma_wr_addr, dma_wr_data});
    @(posedge clk);
    #1;
    if (obs_pop && fq.size() > 0) void'(fq.pop_front());
    fifo_drive();
  end

  // Bus helpers
  task automatic bus_idle();
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
  endtask
  task automatic wr_now(input logic [7:0] off, input logic [31:0] d, input logic [3:0] s);
    req_valid = 1'b1; req_write = 1'b1; req_addr = {24'h0, off}; req_wdata = d; req_wstrb = s;
    @(posedge clk); #1;
    bus_idle();
  endtask
  task automatic wr(input logic [7:0] off, input logic [31:0] d);
    @(negedge clk);
    wr_now(off, d, 4'hF);
  endtask
  task automatic rd(input logic [7:0] off, output logic [31:0] v);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = {24'h0, off};
    #1 v = rdata;
    @(posedge clk); #1;
    bus_idle();
  endtask
  task automatic wait_idle(input int max, input string nm);
    logic [31:0] v;
    int n;
    n = 0;
    rd(8'h08, v);
    while (v[3] && n < max) begin rd(8'h08, v); n++; end
    check({nm, "_idle"}, 64'(v[3]), 64'h0);
  endtask

  logic [31:0] v;
  logic [63:0] g;
  int p0, r;
  logic [31:0] exp_a[4];
  logic [31:0] exp_d[4];
  logic [7:0]  offs[6];

  initial begin
    bus_idle();
    fifo_drive();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_rdata", 64'(rdata), 64'h0);
    check("reset_pop", 64'(out_fifo_pop), 64'h0);
    check("reset_wr_en", 64'(dma_wr_en), 64'h0);
    check("reset_wr_addr", 64'(dma_wr_addr), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic two-entry transfer with literal expectations
    wlog.delete(); p0 = pop_cnt;
    push(49'h1_2345_6789_ABCD);
    push(49'h0_0000_0000_0001);
    wr(8'h00, 32'h100); wr(8'h04, 32'd4); wr(8'h08, 32'h1);
    wait_idle(40, "basic");
    exp_a = '{32'h100, 32'h104, 32'h108, 32'h10C};
    exp_d = '{32'h6789ABCD, 32'h00012345, 32'h00000001, 32'h00000000};
    check("basic_nwr", 64'(wlog.size()), 64'd4);
    for (int i = 0; i < 4 && i < wlog.size(); i++) begin
      check("basic_addr", 64'(wlog[i].a), 64'(exp_a[i]));
      check("basic_data", 64'(wlog[i].d), 64'(exp_d[i]));
    end
    check("basic_pops", 64'(pop_cnt - p0), 64'd2);
    rd(8'h08, v); check("basic_ctrl", 64'(v), 64'h2);
    rd(8'h0C, v); check("basic_words_done", 64'(v), 64'd4);

    // Odd length and misaligned destination
    flush(); push(49'h1_FFFF_0000_FFFF);
    wlog.delete(); p0 = pop_cnt;
    wr(8'h04, 32'd3); wr(8'h08, 32'h1);
    rd(8'h08, v); check("odd_len_ctrl", 64'(v), 64'h6);
    wr(8'h08, 32'h6);
    rd(8'h08, v); check("w1c_ctrl", 64'(v), 64'h0);
    wr(8'h00, 32'h102); wr(8'h04, 32'd2); wr(8'h08, 32'h1);
    rd(8'h08, v); check("misalign_ctrl", 64'(v), 64'h6);
    check("err_nwr", 64'(wlog.size()), 64'd0);
    check("err_pops", 64'(pop_cnt - p0), 64'd0);
    flush();

    // Starved FIFO
    wr(8'h08, 32'h6); wr(8'h00, 32'h40); wr(8'h04, 32'd2); wr(8'h08, 32'h1);
    for (int i = 0; i < 10; i++) begin
      rd(8'h08, v);
      check("starve_busy", 64'(v[3]), 64'h1);
      check("starve_pop", 64'(out_fifo_pop), 64'h0);
    end
    @(negedge clk); push(49'h0_AAAA_5555_1234);
    #1 check("starve_pop_now", 64'(out_fifo_pop), 64'h1);
    @(negedge clk);
    #1 check("starve_wr0", {dma_wr_en, dma_wr_addr, dma_wr_data}, {31'h0, 1'b1, 32'h40, 32'h55551234});
    @(negedge clk);
    #1 check("starve_wr1", {dma_wr_en, dma_wr_addr, dma_wr_data}, {31'h0, 1'b1, 32'h44, 32'h0000AAAA});
    wait_idle(10, "starve");

    // Abort after the first pair
    flush(); wlog.delete();
    wr(8'h08, 32'h6); wr(8'h00, 32'h300); wr(8'h04, 32'd8);
    for (int i = 0; i < 4; i++) begin g = {$urandom(), $urandom()}; push(g[48:0]); end
    p0 = pop_cnt;
    wr(8'h08, 32'h1);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (wlog.size() >= 2) break;
    end
    wr_now(8'h08, 32'h10, 4'hF);
    rd(8'h08, v); check("abort_ctrl", 64'(v), 64'h6);
    rd(8'h0C, v); check("abort_words_done", 64'(v), 64'd2);
    check("abort_nwr", 64'(wlog.size()), 64'd2);
    check("abort_pops", 64'(pop_cnt - p0), 64'd1);

    // START/DST while busy; W1C coinciding with completion
    flush(); wlog.delete();
    wr(8'h08, 32'h6); wr(8'h00, 32'h500); wr(8'h04, 32'd4);
    push(49'h0_0000_1111_2222); push(49'h1_0000_3333_4444);
    wr(8'h08, 32'h1); wr(8'h00, 32'h200); wr(8'h08, 32'h1);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (dma_wr_en && dma_wr_addr == 32'h50C) break;
    end
    wr_now(8'h08, 32'h6, 4'hF);
    rd(8'h08, v); check("busy_start_ctrl", 64'(v), 64'h2);
    rd(8'h00, v); check("busy_dst_reg", 64'(v), 64'h200);
    check("busy_nwr", 64'(wlog.size()), 64'd4);
    for (int i = 0; i < 4 && i < wlog.size(); i++)
      check("busy_addr", 64'(wlog[i].a), 64'(32'h500 + 32'(4 * i)));

    // Reset during the first write
    flush(); wlog.delete();
    wr(8'h08, 32'h6); wr(8'h00, 32'h600); wr(8'h04, 32'd2);
    push(49'h1_5A5A_A5A5_5A5A);
    wr(8'h08, 32'h1);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (dma_wr_en) break;
    end
    rst_n = 1'b0;
    #1;
    check("rst_outputs", {out_fifo_pop, dma_wr_en, dma_wr_addr, dma_wr_data}, 64'h0);
    check("rst_rdata", 64'(rdata), 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("rst_nwr", 64'(wlog.size()), 64'd0);
    rd(8'h08, v); check("rst_ctrl", 64'(v), 64'h0);
    flush();

    // Randomized traffic
    offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'hF4};
    for (int it = 0; it < 2500; it++) begin
      @(negedge clk);
      if ($urandom_range(0, 9) < 4 && fq.size() < 6) begin
        g = {$urandom(), $urandom()};
        push(g[48:0]);
      end
      r = $urandom_range(0, 99);
      if (r >= 45) begin
        req_valid = 1'b1;
        req_write = 1'b1;
        req_wstrb = ($urandom_range(0, 3) == 0) ? 4'($urandom()) : 4'hF;
        req_addr  = {24'($urandom()), 8'h08};
        if (r < 55) begin
          req_write = 1'b0;
          req_addr  = {24'($urandom()), offs[$urandom_range(0, 5)]};
        end else if (r < 72) begin
          req_wdata = ($urandom() & 32'h6) | 32'h1 | (($urandom_range(0, 9) == 0) ? 32'h10 : 32'h0);
        end else if (r < 78) begin
          req_wdata = ($urandom() & 32'h6) | 32'h10;
        end else if (r < 89) begin
          req_addr[7:0] = 8'h00;
          case ($urandom_range(0, 5))
            0:       req_wdata = 32'hFFFF_FFF8;
            1:       req_wdata = $urandom();
            default: req_wdata = $urandom() & 32'hFFFF_FFFC;
          endcase
        end else if (r < 97) begin
          req_addr[7:0] = 8'h04;
          req_wdata = 32'($urandom_range(0, 12));
        end else begin
          req_addr[7:0] = offs[$urandom_range(3, 5)];
          req_wdata = $urandom();
        end
        @(posedge clk); #1;
        bus_idle();
      end
    end
    wr(8'h08, 32'h10);
    wait_idle(5, "final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
